// File: rtl/id_operand_stage_pkg.sv
// Shared definitions for the IF/ID operand stage: stall bus encoding and IF->ID bus.
package id_operand_stage_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Bit positions on the stall bus
  localparam int STALL_IFID = 1;
  localparam int STALL_ID   = 2;

  // IF->ID slot payload: valid flag plus 32-bit pc
  localparam int IF_ID_BUS_W = 33;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
  } if_id_bus_t;

endpackage

// File: rtl/id_operand_stage_fwd_select.sv
// Per-operand forwarding mux: lowest-index matching channel wins, reports its pending flag.
module id_operand_stage_fwd_select #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NFWD   = 3
) (
  input  logic                 slot_valid,
  input  logic [AW-1:0]        addr,
  input  logic [DATA_W-1:0]    rf_rdata,
  input  logic [NFWD-1:0]      fwd_we,
  input  logic [NFWD*AW-1:0]   fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  input  logic [NFWD-1:0]      fwd_pending,
  output logic [DATA_W-1:0]    data,
  output logic                 pending
);

  logic hit;

  // Priority scan from the youngest channel; r0 and empty slots force zero and no hazard
  always_comb begin
    data    = rf_rdata;
    pending = 1'b0;
    hit     = 1'b0;
    for (int i = 0; i < NFWD; i++) begin
      if (!hit && fwd_we[i] && (fwd_waddr[i*AW +: AW] == addr)) begin
        hit     = 1'b1;
        data    = fwd_wdata[i*DATA_W +: DATA_W];
        pending = fwd_pending[i];
      end
    end
    if (!slot_valid || (addr == '0)) begin
      data    = '0;
      pending = 1'b0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// IF/ID slot register, instruction hold across stalls, forwarded operand fetch and load-use detect.
import id_operand_stage_pkg::*;

module id_operand_stage #(
  parameter int DATA_W = 32,
  parameter int AW     = 5,
  parameter int NFWD   = 3,
  parameter int SB_W   = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SB_W-1:0]        stall,
  input  logic                   if_ce,
  input  logic [31:0]            if_pc,
  input  logic [31:0]            inst_sram_rdata,
  output logic [AW-1:0]          rf_raddr1,
  output logic [AW-1:0]          rf_raddr2,
  input  logic [DATA_W-1:0]      rf_rdata1,
  input  logic [DATA_W-1:0]      rf_rdata2,
  input  logic [NFWD-1:0]        fwd_we,
  input  logic [NFWD*AW-1:0]     fwd_waddr,
  input  logic [NFWD*DATA_W-1:0] fwd_wdata,
  input  logic [NFWD-1:0]        fwd_pending,
  output logic                   id_valid,
  output logic [31:0]            id_pc,
  output logic [31:0]            id_inst,
  output logic [DATA_W-1:0]      src1,
  output logic [DATA_W-1:0]      src2,
  output logic                   stallreq,
  output logic [31:0]            hazard_cnt
);

  if_id_bus_t  slot_q;
  logic        hold_vld;
  logic [31:0] inst_hold;
  logic        bubble;
  logic        load;
  logic        pend1;
  logic        pend2;
  logic        unused_stall;

  assign bubble = (stall[STALL_IFID] == STOP) && (stall[STALL_ID] == NO_STOP);
  assign load   = (stall[STALL_IFID] == NO_STOP);
  assign unused_stall = ^{stall[SB_W-1:3], stall[0]};

  assign id_valid = slot_q.valid;
  assign id_pc    = slot_q.pc;

  // Slot register: bubble on IF/ID stop with ID moving, otherwise load or hold
  always_ff @(posedge clk) begin
    if (rst)         slot_q <= '0;
    else if (bubble) slot_q <= '0;
    else if (load)   slot_q <= '{valid: if_ce, pc: if_pc};
  end

  // SRAM data is only valid one cycle, so latch it on the first stalled cycle
  always_ff @(posedge clk) begin
    if (rst || bubble || load) begin
      hold_vld <= 1'b0;
    end else if (slot_q.valid && (stall[STALL_ID] == STOP) && !hold_vld) begin
      hold_vld  <= 1'b1;
      inst_hold <= inst_sram_rdata;
    end
  end

  assign id_inst   = !slot_q.valid ? 32'h0 : (hold_vld ? inst_hold : inst_sram_rdata);
  assign rf_raddr1 = id_inst[21 +: AW];
  assign rf_raddr2 = id_inst[16 +: AW];

  id_operand_stage_fwd_select #(.DATA_W(DATA_W), .AW(AW), .NFWD(NFWD)) u_fwd_rs (
    .slot_valid (slot_q.valid),
    .addr       (rf_raddr1),
    .rf_rdata   (rf_rdata1),
    .fwd_we     (fwd_we),
    .fwd_waddr  (fwd_waddr),
    .fwd_wdata  (fwd_wdata),
    .fwd_pending(fwd_pending),
    .data       (src1),
    .pending    (pend1)
  );

  id_operand_stage_fwd_select #(.DATA_W(DATA_W), .AW(AW), .NFWD(NFWD)) u_fwd_rt (
    .slot_valid (slot_q.valid),
    .addr       (rf_raddr2),
    .rf_rdata   (rf_rdata2),
    .fwd_we     (fwd_we),
    .fwd_waddr  (fwd_waddr),
    .fwd_wdata  (fwd_wdata),
    .fwd_pending(fwd_pending),
    .data       (src2),
    .pending    (pend2)
  );

  assign stallreq = slot_q.valid && (pend1 || pend2);

  // Saturating count of load-use stall cycles
  always_ff @(posedge clk) begin
    if (rst)                                  hazard_cnt <= '0;
    else if (stallreq && (hazard_cnt != '1))  hazard_cnt <= hazard_cnt + 32'd1;
  end

endmodule
